div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_div_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter (with helper div4_comb)
// Purpose  : Shares one 4-bit combinational divider between two requesters.
//            Round-robin grant, one transaction in flight, operands held on
//            the divider for SETTLE_CYCLES cycles before the result is
//            captured and presented with a valid/ready handshake.
// Params   : SETTLE_CYCLES (1..15) - cycles operands settle on the divider.
// Macro    : DIV_ARB_ZERO_CHECK_EN - when defined, den=0 bypasses the divider
//            and responds next cycle with err=1, quot=4'hF, rem=num.
// Ports    : clk, rst (async, active-high)
//            req{0,1}_valid/_num/_den in, req{0,1}_ready out (combinational)
//            rsp_valid/_id/_quot/_rem/_err out (registered), rsp_ready in
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// div4_comb : existing 4-bit restoring divider, purely combinational.
// A zero denominator yields quot=4'hF, rem=num (every trial subtract passes).
// ----------------------------------------------------------------------------
module div4_comb (
  input  logic [3:0] num_i,
  input  logic [3:0] den_i,
  output logic [3:0] quot_o,
  output logic [3:0] rem_o
);

  logic [4:0] part;

  always_comb begin
    part   = 5'd0;
    quot_o = 4'd0;
    for (int i = 3; i >= 0; i--) begin
      part = {part[3:0], num_i[i]};
      if (part >= {1'b0, den_i}) begin
        part      = part - {1'b0, den_i};
        quot_o[i] = 1'b1;
      end
    end
    rem_o = part[3:0];
  end

endmodule

module div_arbiter #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_num,
  input  logic [3:0] req0_den,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_num,
  input  logic [3:0] req1_den,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_quot,
  output logic [3:0] rsp_rem,
  output logic       rsp_err,
  input  logic       rsp_ready
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t     state_q;
  logic       rr_q;          // requester with priority when both are valid
  logic       id_q;
  logic [3:0] num_q;
  logic [3:0] den_q;
  logic [3:0] cnt_q;
  logic [3:0] quot_q;
  logic [3:0] rem_q;
  logic       rsp_valid_q;

  logic       gnt0_d;
  logic       gnt1_d;
  logic       accept_d;
  logic [3:0] acc_num_d;
  logic [3:0] acc_den_d;
  logic [3:0] div_quot;
  logic [3:0] div_rem;

  div4_comb u_div (
    .num_i  (num_q),
    .den_i  (den_q),
    .quot_o (div_quot),
    .rem_o  (div_rem)
  );

  // Grant is only offered in IDLE; rst gates it so ready is 0 throughout reset
  // even if valids are held high.
  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    if (!rst && state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0_d = ~rr_q;
        gnt1_d = rr_q;
      end else begin
        gnt0_d = req0_valid;
        gnt1_d = req1_valid;
      end
    end
  end

  assign accept_d  = (gnt0_d && req0_valid) || (gnt1_d && req1_valid);
  assign acc_num_d = gnt1_d ? req1_num : req0_num;
  assign acc_den_d = gnt1_d ? req1_den : req0_den;

  assign req0_ready = gnt0_d;
  assign req1_ready = gnt1_d;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_quot   = quot_q;
  assign rsp_rem    = rem_q;

`ifdef DIV_ARB_ZERO_CHECK_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      num_q       <= 4'd0;
      den_q       <= 4'd0;
      cnt_q       <= 4'd0;
      quot_q      <= 4'd0;
      rem_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
`ifdef DIV_ARB_ZERO_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            num_q <= acc_num_d;
            den_q <= acc_den_d;
            id_q  <= gnt1_d;
            cnt_q <= CNT_INIT;
`ifdef DIV_ARB_ZERO_CHECK_EN
            if (acc_den_d == 4'd0) begin
              // Divider result is meaningless here; respond directly.
              quot_q      <= 4'hF;
              rem_q       <= acc_num_d;
              err_q       <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              err_q   <= 1'b0;
              state_q <= ST_SETTLE;
            end
`else
            state_q <= ST_SETTLE;
`endif
          end
        end

        ST_SETTLE: begin
          // Counter runs SETTLE_CYCLES..1; the divider output is sampled on
          // the last settle cycle.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            quot_q      <= div_quot;
            rem_q       <= div_rem;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_q        <= ~id_q;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_arbiter
// Purpose  : Directed self-checking bench for div_arbiter (SETTLE_CYCLES=1).
//            Expectations follow DIV_ARB_ZERO_CHECK_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_num, req0_den, req1_num, req1_den;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [3:0] rsp_quot, rsp_rem;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_num   (req0_num),
    .req0_den   (req0_den),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_num   (req1_num),
    .req1_den   (req1_den),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_quot   (rsp_quot),
    .rsp_rem    (rsp_rem),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {20'd0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err},
             32'd0);
  endtask

  // Drive one request pattern, wait for a grant, then for the response.
  // Latency counts negedge samples after the grant cycle.
  task automatic run_txn(input string tag,
                         input logic v0, input logic [3:0] n0, input logic [3:0] d0,
                         input logic v1, input logic [3:0] n1, input logic [3:0] d1,
                         input logic eid, input logic [3:0] eq, input logic [3:0] er,
                         input logic ee, input int elat);
    int k;
    @(negedge clk);
    req0_valid = v0; req0_num = n0; req0_den = d0;
    req1_valid = v1; req1_num = n1; req1_den = d1;
    #1;
    k = 0;
    while (!(req0_ready || req1_ready) && k < 10) begin
      @(negedge clk); #1; k++;
    end
    check_eq({tag, "_one_grant"}, {31'd0, req0_ready ^ req1_ready}, 32'd1);
    check_eq({tag, "_gnt_id"}, {31'd0, req1_ready}, {31'd0, eid});
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk); k++;
      if (!rsp_valid)
        check_eq({tag, "_ready_in_settle"}, {31'd0, req0_ready | req1_ready}, 32'd0);
    end
    check_eq({tag, "_latency"}, k, elat);
    check_eq({tag, "_id"},   {31'd0, rsp_id},  {31'd0, eid});
    check_eq({tag, "_quot"}, {28'd0, rsp_quot}, {28'd0, eq});
    check_eq({tag, "_rem"},  {28'd0, rsp_rem},  {28'd0, er});
    check_eq({tag, "_err"},  {31'd0, rsp_err},  {31'd0, ee});
  endtask

  initial begin
    int k;
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_num = 4'd3; req0_den = 4'd1;
    req1_valid = 1'b1; req1_num = 4'd3; req1_den = 4'd1;

    // Reset state: all outputs 0 even with both valids high.
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    // Basic: 13/6 -> q2 r1, valid 2 cycles after acceptance.
    run_txn("basic", 1, 4'd13, 4'd6, 0, 4'd0, 4'd1, 0, 4'd2, 4'd1, 0, SETTLE + 1);

    // Re-reset so the pointer returns to requester 0.
    @(negedge clk); rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    #1 check_all_zero("rereset");
    @(negedge clk); rst = 1'b0;

    // Simultaneous: 15/4 wins first (id0), then 9/2 (id1).
    run_txn("sim_a", 1, 4'd15, 4'd4, 1, 4'd9, 4'd2, 0, 4'd3, 4'd3, 0, SETTLE + 1);
    run_txn("sim_b", 1, 4'd15, 4'd4, 1, 4'd9, 4'd2, 1, 4'd4, 4'd1, 0, SETTLE + 1);

    // Round-robin over four back-to-back transactions.
    run_txn("rr0", 1, 4'd15, 4'd4, 1, 4'd9, 4'd2, 0, 4'd3, 4'd3, 0, SETTLE + 1);
    run_txn("rr1", 1, 4'd15, 4'd4, 1, 4'd9, 4'd2, 1, 4'd4, 4'd1, 0, SETTLE + 1);
    run_txn("rr2", 1, 4'd15, 4'd4, 1, 4'd9, 4'd2, 0, 4'd3, 4'd3, 0, SETTLE + 1);
    run_txn("rr3", 1, 4'd15, 4'd4, 1, 4'd9, 4'd2, 1, 4'd4, 4'd1, 0, SETTLE + 1);

    // Backpressure: 7/3 held 5 cycles with req1 still valid.
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_num = 4'd7; req0_den = 4'd3;
    req1_valid = 1'b1; req1_num = 4'd9; req1_den = 4'd2;
    #1;
    check_eq("bp_gnt", {30'd0, req0_ready, req1_ready}, 32'd2);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk); k++;
    end
    check_eq("bp_latency", k, SETTLE + 1);
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp_qr", {24'd0, rsp_quot, rsp_rem}, 32'h21);
      check_eq("bp_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("bp_released", {31'd0, rsp_valid}, 32'd0);
    check_eq("bp_next_gnt", {30'd0, req0_ready, req1_ready}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Pointer now favours requester 1 (consumed by the request below).
`ifdef DIV_ARB_ZERO_CHECK_EN
    run_txn("zero", 0, 4'd0, 4'd1, 1, 4'd5, 4'd0, 1, 4'hF, 4'd5, 1, 1);
`else
    run_txn("zero", 0, 4'd0, 4'd1, 1, 4'd5, 4'd0, 1, 4'hF, 4'd5, 0, SETTLE + 1);
`endif

    // Serve requester 0 so the pointer favours requester 1 before the abort.
    run_txn("pre_abort", 1, 4'd13, 4'd6, 0, 4'd0, 4'd1, 0, 4'd2, 4'd1, 0, SETTLE + 1);

    // Reset mid-op: accept req1 9/2, reset while in SETTLE.
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_num = 4'd9; req1_den = 4'd2;
    #1 check_eq("abort_gnt", {30'd0, req0_ready, req1_ready}, 32'd1);
    @(negedge clk);
    check_eq("abort_in_settle", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    #1 check_all_zero("abort_rst");
    @(negedge clk);
    rst = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    run_txn("post_abort", 1, 4'd15, 4'd4, 1, 4'd9, 4'd2, 0, 4'd3, 4'd3, 0, SETTLE + 1);

    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
